psola_out_streamer: RTL

PSOLA_OUT_STREAMER -- requirements
Module: psola_out_streamer

---
 rtl/psola_pkg.sv | 14 +
 rtl/psola_sample_scale.sv | 34 +++
 rtl/psola_out_streamer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/psola_pkg.sv
// Shared state encoding and default widths for the PSOLA output streamer.
package psola_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } psola_state_e;

    localparam int PSOLA_WINDOW_SIZE = 2048;
    localparam int PSOLA_FRAC_BITS   = 10;
    localparam int PSOLA_OUT_WIDTH   = 16;
    localparam int PSOLA_WORD_W      = 32;

endpackage

// File: rtl/psola_sample_scale.sv
// Converts a fixed-point frame word to an OUT_WIDTH audio sample.
// Build option PSOLA_OUT_SAT_EN: clamp to the output range instead of wrapping.
module psola_sample_scale
    import psola_pkg::*;
#(
    parameter int FRAC_BITS = PSOLA_FRAC_BITS,
    parameter int OUT_WIDTH = PSOLA_OUT_WIDTH
) (
    input  logic signed [PSOLA_WORD_W-1:0] word_in,
    output logic signed [OUT_WIDTH-1:0]    sample_out
);

`ifdef PSOLA_OUT_SAT_EN
    localparam int SAT_MAX = (1 << (OUT_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OUT_WIDTH - 1));

    logic signed [PSOLA_WORD_W-1:0] shifted;

    always_comb begin
        shifted = word_in >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            sample_out = OUT_WIDTH'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            sample_out = OUT_WIDTH'(SAT_MIN);
        end else begin
            sample_out = shifted[OUT_WIDTH-1:0];
        end
    end
`else
    // Keeps only the low OUT_WIDTH bits of the integer part.
    assign sample_out = OUT_WIDTH'(word_in >>> FRAC_BITS);
`endif

endmodule

// File: rtl/psola_out_streamer.sv
// Ping-pong frame buffer that plays PSOLA output frames one word per audio tick.
// Build option PSOLA_OUT_SAT_EN selects saturating sample conversion (see psola_sample_scale).
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no bank being played; ticks produce a zero sample and underrun
// ST_PLAY | streaming play_bank_q, one word per tick, rd_ptr_q is next word
module psola_out_streamer
    import psola_pkg::*;
#(
    parameter int WINDOW_SIZE = PSOLA_WINDOW_SIZE,
    parameter int FRAC_BITS   = PSOLA_FRAC_BITS,
    parameter int OUT_WIDTH   = PSOLA_OUT_WIDTH
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           frame_valid_in,
    input  logic signed [PSOLA_WORD_W-1:0] frame_in [0:2*WINDOW_SIZE-1],
    input  logic [11:0]                    frame_len_in,
    input  logic                           sample_tick_in,
    output logic signed [OUT_WIDTH-1:0]    sample_out,
    output logic                           sample_valid_out,
    output logic                           busy_out,
    output logic                           underrun_out,
    output logic                           dropped_frame_out
);

    localparam int unsigned DEPTH = 2 * WINDOW_SIZE;
    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          PTR_W = IDX_W + 1;

    psola_state_e                   state_q, state_d;
    logic                           play_bank_q, play_bank_d;
    logic [IDX_W-1:0]               rd_ptr_q, rd_ptr_d;
    logic [1:0]                     full_q, full_d;
    logic [PTR_W-1:0]               bank_len_q [0:1];
    logic [PTR_W-1:0]               bank_len_d [0:1];
    logic signed [OUT_WIDTH-1:0]    sample_q, sample_d;
    logic                           sample_valid_q, sample_valid_d;
    logic                           underrun_q, underrun_d;
    logic                           dropped_q, dropped_d;

    logic signed [PSOLA_WORD_W-1:0] bank_mem_q [0:1][0:DEPTH-1];

    logic                           cap_en;
    logic                           cap_bank;
    logic                           other_bank;
    logic                           last_word;
    logic [PTR_W-1:0]               eff_len;
    logic signed [PSOLA_WORD_W-1:0] rd_word;
    logic signed [OUT_WIDTH-1:0]    scaled;

    assign other_bank = ~play_bank_q;
    assign rd_word    = bank_mem_q[play_bank_q][rd_ptr_q];
    assign last_word  = ({1'b0, rd_ptr_q} == (bank_len_q[play_bank_q] - PTR_W'(1)));
    assign eff_len    = (32'(frame_len_in) > DEPTH) ? PTR_W'(DEPTH) : PTR_W'(frame_len_in);

    psola_sample_scale #(
        .FRAC_BITS (FRAC_BITS),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_scale (
        .word_in    (rd_word),
        .sample_out (scaled)
    );

    always_comb begin
        state_d        = state_q;
        play_bank_d    = play_bank_q;
        rd_ptr_d       = rd_ptr_q;
        full_d         = full_q;
        bank_len_d     = bank_len_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        underrun_d     = 1'b0;
        dropped_d      = 1'b0;
        cap_en         = 1'b0;
        cap_bank       = 1'b0;

        // While playing, only the other bank may be written; when idle, take the first free one.
        if (frame_valid_in && (frame_len_in != 12'd0)) begin
            if (state_q == ST_PLAY) begin
                cap_bank = other_bank;
                cap_en   = !full_q[other_bank];
            end else begin
                cap_bank = full_q[0];
                cap_en   = !(full_q[0] && full_q[1]);
            end
            dropped_d = !cap_en;
        end

        if (cap_en) begin
            full_d[cap_bank]     = 1'b1;
            bank_len_d[cap_bank] = eff_len;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_tick_in) begin
                    sample_d       = '0;
                    sample_valid_d = 1'b1;
                    underrun_d     = 1'b1;
                end
                if (full_q[0] || full_q[1]) begin
                    state_d     = ST_PLAY;
                    play_bank_d = ~full_q[0];
                    rd_ptr_d    = '0;
                end
            end
            ST_PLAY: begin
                if (sample_tick_in) begin
                    sample_d       = scaled;
                    sample_valid_d = 1'b1;
                    if (last_word) begin
                        full_d[play_bank_q] = 1'b0;
                        rd_ptr_d            = '0;
                        // A capture this cycle always targets the other bank, so it can follow on.
                        if (full_q[other_bank] || cap_en) begin
                            play_bank_d = other_bank;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= ST_IDLE;
            play_bank_q    <= 1'b0;
            rd_ptr_q       <= '0;
            full_q         <= '0;
            bank_len_q[0]  <= '0;
            bank_len_q[1]  <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
            dropped_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            play_bank_q    <= play_bank_d;
            rd_ptr_q       <= rd_ptr_d;
            full_q         <= full_d;
            bank_len_q     <= bank_len_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            underrun_q     <= underrun_d;
            dropped_q      <= dropped_d;
        end
    end

    // Words beyond the frame length are copied too but never read.
    always_ff @(posedge clk_in) begin
        if (cap_en) begin
            bank_mem_q[cap_bank] <= frame_in;
        end
    end

    assign sample_out        = sample_q;
    assign sample_valid_out  = sample_valid_q;
    assign busy_out          = (state_q == ST_PLAY);
    assign underrun_out      = underrun_q;
    assign dropped_frame_out = dropped_q;

endmodule
